// File: rtl/baud_tick_gen.sv
// rtl/baud_tick_gen.sv - fractional baud/oversample tick generator
// One os_tick per P = act_int + carry clocks, with phase tracking, bit/mid markers and os_clk.
module baud_tick_gen #(
   parameter int DIV_W        = 16,
   parameter int FRAC_W       = 4,
   parameter int OSR          = 16,
   parameter int DEFAULT_DIV  = 325,
   parameter int DEFAULT_FRAC = 8
) (
   input  logic                    clk_i,
   input  logic                    rst_i,
   input  logic                    en_i,
   input  logic                    load_i,
   input  logic [DIV_W-1:0]        div_int_i,
   input  logic [FRAC_W-1:0]       div_frac_i,
   input  logic                    resync_i,
   output logic                    os_tick_o,
   output logic                    mid_tick_o,
   output logic                    bit_tick_o,
   output logic                    os_clk_o,
   output logic [$clog2(OSR)-1:0]  os_phase_o,
   output logic                    cfg_err_o
);

   localparam int PH_W = $clog2(OSR);

   logic [DIV_W:0]    cnt_q, cnt_d;
   logic [FRAC_W-1:0] acc_q, acc_d;
   logic [PH_W-1:0]   phase_q, phase_d;
   logic              os_clk_q, os_clk_d;
   logic              tick_q, tick_d, mid_q, mid_d, bit_q, bit_d;
   logic [DIV_W-1:0]  act_int_q, act_int_d, pend_int_q, pend_int_d;
   logic [FRAC_W-1:0] act_frac_q, act_frac_d, pend_frac_q, pend_frac_d;
   logic              pend_vld_q, pend_vld_d;
   logic              cfg_err_q, cfg_err_d;

   logic [FRAC_W:0]   sum;
   logic [DIV_W:0]    period;
   logic [DIV_W:0]    last;
   logic [PH_W-1:0]   phase_inc;
   logic              load_ok;
   logic              wrap;

   // The carry of the fractional accumulator stretches this period by one clock.
   assign sum       = {1'b0, acc_q} + {1'b0, act_frac_q};
   assign period    = {1'b0, act_int_q} + {{DIV_W{1'b0}}, sum[FRAC_W]};
   assign last      = period - {{DIV_W{1'b0}}, 1'b1};
   assign wrap      = en_i && (cnt_q == last);
   assign phase_inc = phase_q + 1'b1;
   assign load_ok   = load_i && (div_int_i >= DIV_W'(2));

   always_comb begin
      cnt_d       = cnt_q;
      acc_d       = acc_q;
      phase_d     = phase_q;
      os_clk_d    = os_clk_q;
      tick_d      = 1'b0;
      mid_d       = 1'b0;
      bit_d       = 1'b0;
      act_int_d   = act_int_q;
      act_frac_d  = act_frac_q;
      pend_int_d  = pend_int_q;
      pend_frac_d = pend_frac_q;
      pend_vld_d  = pend_vld_q;
      cfg_err_d   = cfg_err_q;

      if (load_i) begin
         if (load_ok) begin
            pend_int_d  = div_int_i;
            pend_frac_d = div_frac_i;
            pend_vld_d  = 1'b1;
            cfg_err_d   = 1'b0;
         end else begin
            cfg_err_d   = 1'b1;
         end
      end

      if (resync_i) begin
         cnt_d   = '0;
         acc_d   = '0;
         phase_d = '0;
         if (load_ok) begin
            act_int_d  = div_int_i;
            act_frac_d = div_frac_i;
            pend_vld_d = 1'b0;
         end
      end else if (en_i) begin
         if (wrap) begin
            cnt_d    = '0;
            acc_d    = sum[FRAC_W-1:0];
            phase_d  = phase_inc;
            os_clk_d = ~os_clk_q;
            tick_d   = 1'b1;
            bit_d    = (phase_inc == '0);
            mid_d    = (phase_inc == PH_W'(OSR / 2));
            // A load landing on the wrap cycle stays pending for the following period.
            if (pend_vld_q) begin
               act_int_d  = pend_int_q;
               act_frac_d = pend_frac_q;
               if (!load_ok) pend_vld_d = 1'b0;
            end
         end else begin
            cnt_d = cnt_q + 1'b1;
         end
      end
   end

   always_ff @(posedge clk_i) begin
      if (rst_i) begin
         cnt_q       <= '0;
         acc_q       <= '0;
         phase_q     <= '0;
         os_clk_q    <= 1'b0;
         tick_q      <= 1'b0;
         mid_q       <= 1'b0;
         bit_q       <= 1'b0;
         act_int_q   <= DIV_W'(DEFAULT_DIV);
         act_frac_q  <= FRAC_W'(DEFAULT_FRAC);
         pend_int_q  <= DIV_W'(DEFAULT_DIV);
         pend_frac_q <= FRAC_W'(DEFAULT_FRAC);
         pend_vld_q  <= 1'b0;
         cfg_err_q   <= 1'b0;
      end else begin
         cnt_q       <= cnt_d;
         acc_q       <= acc_d;
         phase_q     <= phase_d;
         os_clk_q    <= os_clk_d;
         tick_q      <= tick_d;
         mid_q       <= mid_d;
         bit_q       <= bit_d;
         act_int_q   <= act_int_d;
         act_frac_q  <= act_frac_d;
         pend_int_q  <= pend_int_d;
         pend_frac_q <= pend_frac_d;
         pend_vld_q  <= pend_vld_d;
         cfg_err_q   <= cfg_err_d;
      end
   end

   assign os_tick_o  = tick_q;
   assign mid_tick_o = mid_q;
   assign bit_tick_o = bit_q;
   assign os_clk_o   = os_clk_q;
   assign os_phase_o = phase_q;
   assign cfg_err_o  = cfg_err_q;

endmodule

// File: tb/tb_baud_tick_gen.sv
// tb/tb_baud_tick_gen.sv - directed and random checks of baud_tick_gen against a period-level model
// The model tracks elapsed enabled cycles per period and the divisor schedule with plain integers.
module tb_baud_tick_gen;

   localparam int DIV_W = 16;
   localparam int FRAC_W = 4;
   localparam int OSR = 16;
   localparam int DDIV = 325;
   localparam int DFRAC = 8;
   localparam int FMOD = 1 << FRAC_W;

   logic clk = 1'b0;
   logic rst_i, en_i, load_i, resync_i;
   logic [DIV_W-1:0] div_int_i;
   logic [FRAC_W-1:0] div_frac_i;
   logic os_tick_o, mid_tick_o, bit_tick_o, os_clk_o, cfg_err_o;
   logic [3:0] os_phase_o;

   int total = 0;
   int bad = 0;

   int a_i, a_f, p_i, p_f, p_vld, m_acc, m_el, m_ph, m_clk, m_err, m_tick, m_mid, m_bit;

   baud_tick_gen #(.DIV_W(DIV_W), .FRAC_W(FRAC_W), .OSR(OSR),
                   .DEFAULT_DIV(DDIV), .DEFAULT_FRAC(DFRAC)) dut (
      .clk_i(clk), .rst_i(rst_i), .en_i(en_i), .load_i(load_i),
      .div_int_i(div_int_i), .div_frac_i(div_frac_i), .resync_i(resync_i),
      .os_tick_o(os_tick_o), .mid_tick_o(mid_tick_o), .bit_tick_o(bit_tick_o),
      .os_clk_o(os_clk_o), .os_phase_o(os_phase_o), .cfg_err_o(cfg_err_o));

   always #5 clk = ~clk;

   task automatic chk(input string tag, input int got, input int exp);
      total++;
      assert (got === exp) else begin
         bad++;
         $error("FAIL %s observed=%0d expected=%0d", tag, got, exp);
      end
   endtask

   task automatic model_step(input logic r, input logic e, input logic l,
                             input int di, input int df, input logic rs);
      int old_vld, old_pi, old_pf, per;
      bit ld_ok;
      m_tick = 0; m_mid = 0; m_bit = 0;
      if (r) begin
         a_i = DDIV; a_f = DFRAC; p_i = DDIV; p_f = DFRAC; p_vld = 0;
         m_acc = 0; m_el = 0; m_ph = 0; m_clk = 0; m_err = 0;
         return;
      end
      old_vld = p_vld; old_pi = p_i; old_pf = p_f;
      ld_ok = l && (di >= 2);
      if (l) begin
         if (ld_ok) begin p_i = di; p_f = df; p_vld = 1; m_err = 0; end
         else m_err = 1;
      end
      if (rs) begin
         m_el = 0; m_acc = 0; m_ph = 0;
         if (ld_ok) begin a_i = di; a_f = df; p_vld = 0; end
      end else if (e) begin
         per = a_i + (((m_acc + a_f) >= FMOD) ? 1 : 0);
         m_el++;
         if (m_el == per) begin
            m_el = 0;
            m_acc = (m_acc + a_f) % FMOD;
            m_ph = (m_ph + 1) % OSR;
            m_clk = 1 - m_clk;
            m_tick = 1;
            m_bit = (m_ph == 0);
            m_mid = (m_ph == OSR / 2);
            if (old_vld != 0) begin
               a_i = old_pi; a_f = old_pf;
               if (!ld_ok) p_vld = 0;
            end
         end
      end
   endtask

   task automatic cyc(input logic r, input logic e, input logic l,
                      input int di, input int df, input logic rs);
      rst_i = r; en_i = e; load_i = l; resync_i = rs;
      div_int_i = 16'(di); div_frac_i = 4'(df);
      @(posedge clk);
      model_step(r, e, l, di, df, rs);
      #1;
      chk("cycle_outputs",
          {os_tick_o, mid_tick_o, bit_tick_o, os_clk_o, os_phase_o, cfg_err_o},
          {m_tick[0], m_mid[0], m_bit[0], m_clk[0], 4'(m_ph), m_err[0]});
   endtask

   task automatic idle();
      cyc(1'b0, 1'b1, 1'b0, 0, 0, 1'b0);
   endtask

   // sel: 0 os_tick, 1 bit_tick, 2 mid_tick, 3 os_phase==9
   task automatic wait_sig(input int sel, input int max, output int n);
      logic hit;
      n = -1;
      for (int k = 1; k <= max; k++) begin
         idle();
         case (sel)
            0: hit = os_tick_o;
            1: hit = bit_tick_o;
            2: hit = mid_tick_o;
            default: hit = (os_phase_o == 4'd9);
         endcase
         if (hit) begin n = k; return; end
      end
      total++; bad++;
      $error("FAIL wait_timeout sel=%0d observed=none expected=event within %0d", sel, max);
   endtask

   initial begin
      int n, sum;
      logic clk_prev;
      rst_i = 1'b1; en_i = 1'b0; load_i = 1'b0; resync_i = 1'b0;
      div_int_i = '0; div_frac_i = '0;

      cyc(1'b1, 1'b0, 1'b0, 0, 0, 1'b0);
      cyc(1'b1, 1'b1, 1'b1, 1, 0, 1'b1);
      chk("rst_tick", os_tick_o, 0);
      chk("rst_clk", os_clk_o, 0);
      chk("rst_phase", os_phase_o, 0);
      chk("rst_err", cfg_err_o, 0);

      wait_sig(0, 400, n); chk("default_p1", n, 325);
      wait_sig(0, 400, n); chk("default_p2", n, 326);

      cyc(1'b0, 1'b1, 1'b1, 4, 0, 1'b1);
      wait_sig(0, 10, n); chk("div4_first", n, 4);
      clk_prev = os_clk_o;
      wait_sig(0, 10, n); chk("div4_period", n, 4);
      chk("os_clk_toggle", os_clk_o, int'(!clk_prev));
      wait_sig(1, 100, n);
      wait_sig(1, 100, n); chk("bit_period", n, 64);
      wait_sig(2, 100, n); chk("bit_to_mid", n, 32);

      cyc(1'b0, 1'b1, 1'b1, 4, 8, 1'b1);
      sum = 0;
      for (int k = 0; k < 16; k++) begin
         wait_sig(0, 10, n);
         sum += n;
      end
      chk("frac_16ticks", sum, 72);

      cyc(1'b0, 1'b1, 1'b1, 4, 0, 1'b1);
      idle();
      cyc(1'b0, 1'b1, 1'b1, 6, 0, 1'b0);
      wait_sig(0, 10, n); chk("midload_finish", n, 2);
      wait_sig(0, 10, n); chk("midload_new1", n, 6);
      wait_sig(0, 10, n); chk("midload_new2", n, 6);

      cyc(1'b0, 1'b1, 1'b1, 1, 0, 1'b0);
      chk("bad_load_err", cfg_err_o, 1);
      wait_sig(0, 10, n);
      wait_sig(0, 10, n); chk("bad_load_keep", n, 6);
      cyc(1'b0, 1'b1, 1'b1, 3, 0, 1'b0);
      chk("good_load_err", cfg_err_o, 0);
      wait_sig(0, 10, n);
      wait_sig(0, 10, n); chk("good_load_p3", n, 3);

      wait_sig(3, 100, n);
      clk_prev = os_clk_o;
      cyc(1'b0, 1'b1, 1'b0, 0, 0, 1'b1);
      chk("resync_no_tick", os_tick_o, 0);
      chk("resync_phase", os_phase_o, 0);
      chk("resync_clk_hold", os_clk_o, clk_prev);
      wait_sig(0, 10, n); chk("resync_next", n, 3);
      chk("resync_phase1", os_phase_o, 1);
      wait_sig(0, 10, n);
      cyc(1'b0, 1'b0, 1'b0, 0, 0, 1'b0);
      cyc(1'b0, 1'b0, 1'b0, 0, 0, 1'b1);
      chk("resync_en0_phase", os_phase_o, 0);

      idle();
      cyc(1'b0, 1'b1, 1'b1, 6, 0, 1'b0);
      cyc(1'b1, 1'b1, 1'b1, 5, 0, 1'b1);
      chk("rst_mid_phase", os_phase_o, 0);
      chk("rst_mid_clk", os_clk_o, 0);
      wait_sig(0, 400, n); chk("rst_mid_default", n, 325);

      for (int k = 0; k < 4000; k++) begin
         cyc(($urandom_range(0, 499) == 0),
             ($urandom_range(0, 9) < 8),
             ($urandom_range(0, 19) == 0),
             int'($urandom_range(0, 7)),
             int'($urandom_range(0, FMOD - 1)),
             ($urandom_range(0, 49) == 0));
      end

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule

// File: doc/baud_tick_gen.md
BAUD_TICK_GEN -- requirements
Module: baud_tick_gen

Interface
REQ-001 Parameter DIV_W, default 16, width of integer divisor.
REQ-002 Parameter FRAC_W, default 4, width of fractional divisor.
REQ-003 Parameter OSR, default 16, oversample ticks per bit; legal values 4, 8, 16, 32.
REQ-004 Parameter DEFAULT_DIV, default 325, integer divisor loaded at reset.
REQ-005 Parameter DEFAULT_FRAC, default 8, fractional divisor loaded at reset (325.5 clk/os_tick = 9600 bps x16 at 50 MHz).
REQ-006 clk  in  1  single clock; all logic on rising edge.
REQ-007 rst  in  1  synchronous, active-high reset.
REQ-008 en  in  1  count enable; low freezes all state, no ticks.
REQ-009 load  in  1  one-cycle request to capture div_int/div_frac.
REQ-010 div_int  in  DIV_W  requested integer clocks per os_tick.
REQ-011 div_frac  in  FRAC_W  requested fraction, units of 2^-FRAC_W clock.
REQ-012 resync  in  1  restart bit phase (receiver start-bit alignment).
REQ-013 os_tick  out  1  registered one-cycle pulse at OSR x baud.
REQ-014 mid_tick  out  1  registered pulse coincident with os_tick that sets os_phase to OSR/2.
REQ-015 bit_tick  out  1  registered pulse coincident with os_tick that wraps os_phase to 0.
REQ-016 os_clk  out  1  square wave, toggles on every os_tick.
REQ-017 os_phase  out  log2(OSR)  current oversample index.
REQ-018 cfg_err  out  1  sticky flag: last load rejected.

Function
REQ-019 Active divisor (act_int, act_frac) SHALL define period P = act_int + c clk cycles, c = carry out of acc + act_frac (FRAC_W-bit accumulator acc, updated to the sum mod 2^FRAC_W at each period end).
REQ-020 Cycle counter SHALL count 0..P-1 on enabled cycles only; os_tick SHALL assert in the clock cycle after the counter reaches P-1, exactly one cycle wide.
REQ-021 With en high continuously from reset release and frac 0, os_tick SHALL pulse on enabled cycles P, 2P, 3P... (first enabled cycle = 1).
REQ-022 os_phase SHALL increment modulo OSR on each os_tick, updating in the same cycle os_tick is high.
REQ-023 bit_tick SHALL assert with the os_tick where os_phase becomes 0; mid_tick with the os_tick where os_phase becomes OSR/2; never otherwise.
REQ-024 os_clk SHALL toggle in the cycle os_tick is high.
REQ-025 load with div_int >= 2 SHALL store div_int/div_frac into a pending register; pending SHALL become active at the next period end (the cycle the counter wraps), never mid-period; cfg_err cleared.
REQ-026 load with div_int < 2 SHALL be ignored (active/pending unchanged) and set cfg_err; cfg_err SHALL hold until a valid load or rst.
REQ-027 Multiple valid loads within one period: last one wins.
REQ-028 resync high SHALL clear counter, acc and os_phase next cycle, suppress os_tick/mid_tick/bit_tick that cycle, and leave os_clk unchanged; next os_tick after P enabled cycles.
REQ-029 resync SHALL act regardless of en.
REQ-030 load and resync same cycle: valid divisor SHALL become active immediately and govern the restarted period.
REQ-031 en low: counter, acc, os_phase, os_clk frozen; tick outputs 0; pending load still captured.
REQ-032 Counter width SHALL be DIV_W+1 so P = 2^DIV_W-1+1 cannot overflow.

Reset
REQ-033 rst SHALL override all inputs including resync and load.
REQ-034 After rst: counter=0, acc=0, os_phase=0, os_tick=mid_tick=bit_tick=0, os_clk=0, cfg_err=0, active=pending=(DEFAULT_DIV, DEFAULT_FRAC), no pending-update flag.
REQ-035 rst mid-period SHALL discard the partial period and any pending load.

Verification
REQ-036 Load div_int=4, frac=0, OSR=16, en high -> os_tick every 4 cycles, bit_tick every 64 cycles, mid_tick 32 cycles offset from bit_tick, os_clk period 8.
REQ-037 div_int=4, div_frac=8 (FRAC_W=4) -> periods alternate 4,5,4,5; 16 os_ticks span exactly 72 cycles.
REQ-038 load div_int=6 mid-period at divisor 4 -> current period ends at 4, following periods 6; no runt or double pulse.
REQ-039 load div_int=1 -> cfg_err=1, period unchanged; later load div_int=3 -> cfg_err=0, period 3.
REQ-040 resync at os_phase=9 -> no tick that cycle, os_phase=0, next os_tick after P cycles with os_phase=1; resync while en=0 also clears.
REQ-041 rst asserted mid-period with pending load -> all outputs reset values next cycle; after release period = DEFAULT_DIV+carry pattern of DEFAULT_FRAC.
